// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Receive half of the UART. Deserialises asynchronous frames from the rxd
// line using a sample_tick enable running at OVERSAMPLE x baud. Start, parity
// and stop bits are validated, and each completed character is pushed into
// the RX FIFO write port together with its error flags. The frame format is
// latched when a start edge is detected and held for the whole frame.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : the PARITY state and parity_type decoding are compiled in.
//   undefined : parity_type is ignored, frames go DATA -> STOP1 and
//               parity_err is tied to 0.
//
// Parameters
//   OVERSAMPLE        sample_tick pulses per bit period (power of two, >= 8)
//   SYNC_STAGES       flip-flop stages in the rxd synchronizer
//
// Ports
//   clk               system clock
//   reset             asynchronous, active-low reset
//   sample_tick       one-clk enable at OVERSAMPLE x baud
//   rxd               serial line, idle high, asynchronous
//   data_bits_count   0..3 selects 5..8 data bits
//   parity_type       00 none, 01 even, 10 odd, 11 none
//   double_stop_bits  1 selects two stop bits
//   fifo_full         RX FIFO full
//   err_clr           clears overrun_err
//   dout              received character, right-aligned, upper bits 0
//   dout_valid        one-cycle push strobe to the RX FIFO
//   frame_err         qualifies dout_valid: a stop bit was sampled 0
//   parity_err        qualifies dout_valid: parity mismatch
//   overrun_err       sticky: a character was dropped on a full FIFO
//   busy              high whenever the receiver is not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rxd,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  input  logic       fifo_full,
  input  logic       err_clr,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   last_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             nbits_q, nbits_d;
  logic                   two_stop_q, two_stop_d;
  logic                   ferr_q, ferr_d;
  logic [7:0]             dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic                   at_sample;
  logic                   last_data_bit;
  logic                   complete;
  logic                   ferr_final;

`ifdef UART_RX_PARITY_EN
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   perr_q, perr_d;
  logic                   parity_err_q, parity_err_d;
`else
  logic                   unused_parity_type;
  assign unused_parity_type = ^parity_type;
`endif

  // Synchronizer: every stage resets to the idle (high) line level so that
  // reset release cannot fabricate a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rxd;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // The START sample lands half a bit after the edge; every later sample is a
  // full bit period after the previous one, which keeps all samples mid-bit.
  assign at_sample = sample_tick &&
                     (cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1));

  assign last_data_bit = (bit_idx_q == ({1'b0, nbits_q} + 3'd4));
  assign ferr_final    = ferr_q | ~rxs;

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = sample_tick ? (cnt_q + CW'(1)) : cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    nbits_d      = nbits_q;
    two_stop_d   = two_stop_q;
    ferr_d       = ferr_q;
    complete     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    perr_d       = perr_q;
`endif

    case (state_q)
      IDLE: begin
        // Edge-based detection: a line held low only starts one frame.
        if (sample_tick && !rxs && last_s_q) begin
          state_d    = START;
          cnt_d      = '0;
          bit_idx_d  = '0;
          shift_d    = '0;
          ferr_d     = 1'b0;
          nbits_d    = data_bits_count;
          two_stop_d = double_stop_bits;
`ifdef UART_RX_PARITY_EN
          par_en_d   = (parity_type == 2'b01) || (parity_type == 2'b10);
          par_odd_d  = (parity_type == 2'b10);
          perr_d     = 1'b0;
`endif
        end
      end

      START: begin
        if (at_sample) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? IDLE : DATA;
        end
      end

      DATA: begin
        if (at_sample) begin
          shift_d[bit_idx_q] = rxs;
          if (last_data_bit) begin
            cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP1;
`else
            state_d = STOP1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Unused upper shift bits are 0, so a full-width XOR covers exactly
        // the received data bits.
        if (at_sample) begin
          perr_d  = ((^shift_q) ^ rxs) != par_odd_q;
          cnt_d   = '0;
          state_d = STOP1;
        end
      end
`endif

      STOP1: begin
        if (at_sample) begin
          cnt_d = '0;
          if (two_stop_q) begin
            ferr_d  = ferr_final;
            state_d = STOP2;
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      STOP2: begin
        if (at_sample) begin
          cnt_d    = '0;
          complete = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers. The character and its flags only change on a push, so
  // they hold between frames; an overrun leaves them untouched.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    overrun_d    = err_clr ? 1'b0 : overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    if (complete) begin
      if (!fifo_full) begin
        dout_valid_d = 1'b1;
        dout_d       = shift_q;
        frame_err_d  = ferr_final;
`ifdef UART_RX_PARITY_EN
        parity_err_d = perr_q;
`endif
      end else begin
        // A new overrun wins over a simultaneous clear.
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_s_q     <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      nbits_q      <= '0;
      two_stop_q   <= 1'b0;
      ferr_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      if (sample_tick) begin
        last_s_q <= rxs;
      end
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      nbits_q      <= nbits_d;
      two_stop_q   <= two_stop_d;
      ferr_q       <= ferr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. Frames are driven bit by bit on rxd with
// sample_tick running at one pulse every CLKS_PER_TICK clocks. Each frame that
// should reach the FIFO pushes its expected character and flags into a
// scoreboard queue; a monitor pops and compares on every dout_valid.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int OS            = 16;
  localparam int CLKS_PER_TICK = 4;
  localparam int BIT_CLKS      = OS * CLKS_PER_TICK;

  logic       clk              = 1'b0;
  logic       reset            = 1'b0;
  logic       sample_tick      = 1'b0;
  logic       rxd              = 1'b1;
  logic [1:0] data_bits_count  = 2'd3;
  logic [1:0] parity_type      = 2'b00;
  logic       double_stop_bits = 1'b0;
  logic       fifo_full        = 1'b0;
  logic       err_clr          = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   total       = 0;
  int   bad         = 0;
  int   strobeCount = 0;
  int   expStrobes  = 0;
  int   tickCnt     = 0;
  int   busyCnt     = 0;
  logic prevValid   = 1'b0;

  uart_rx #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_tick     (sample_tick),
    .rxd             (rxd),
    .data_bits_count (data_bits_count),
    .parity_type     (parity_type),
    .double_stop_bits(double_stop_bits),
    .fifo_full       (fifo_full),
    .err_clr         (err_clr),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .frame_err       (frame_err),
    .parity_err      (parity_err),
    .overrun_err     (overrun_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Oversampling enable, one clk wide, every CLKS_PER_TICK clocks.
  always @(negedge clk) begin
    tickCnt++;
    sample_tick = ((tickCnt % CLKS_PER_TICK) == 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectFrame(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    sb.push_back(e);
    expStrobes++;
  endtask

  task automatic sendBit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idleBits(input int n);
    repeat (n) sendBit(1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int nbits,
                               input bit withPar, input logic parBit,
                               input logic stop1, input bit withStop2,
                               input logic stop2);
    sendBit(1'b0);
    for (int i = 0; i < nbits; i++) sendBit(data[i]);
    if (withPar) sendBit(parBit);
    sendBit(stop1);
    if (withStop2) sendBit(stop2);
  endtask

  // Scoreboard monitor: every strobe must be single-cycle and expected.
  always @(negedge clk) begin
    if (dout_valid) begin
      strobeCount++;
      checkOutput("strobe_width", prevValid, 1'b0);
      checkOutput("strobe_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        checkOutput("dout", dout, popped.d);
        checkOutput("frame_err", frame_err, popped.fe);
        checkOutput("parity_err", parity_err, popped.pe);
      end
    end
    prevValid = dout_valid;
  end

  initial begin
    repeat (5) @(negedge clk);
    checkOutput("rst_dout", dout, 8'h00);
    checkOutput("rst_valid", dout_valid, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_parity_err", parity_err, 1'b0);
    checkOutput("rst_overrun", overrun_err, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    reset = 1'b1;
    idleBits(2);

    // 8N1 0xA5
    expectFrame(8'hA5, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8, 0, 1'b0, 1'b1, 0, 1'b1);
    idleBits(1);
    checkOutput("a5_busy", busy, 1'b0);
    checkOutput("a5_count", strobeCount, expStrobes);

    // 5 data bits, 0x15
    data_bits_count = 2'd0;
    expectFrame(8'h15, 1'b0, 1'b0);
    applyStimulus(8'h15, 5, 0, 1'b0, 1'b1, 0, 1'b1);
    idleBits(1);
    checkOutput("b5_upper", dout[7:5], 3'b000);
    data_bits_count = 2'd3;

    // 4-tick low glitch: START rejects it after 8 ticks
    rxd = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i == 15) rxd = 1'b1;
      if (busy) busyCnt++;
    end
    checkOutput("glitch_busy_clks", busyCnt, 8 * CLKS_PER_TICK);
    checkOutput("glitch_no_strobe", strobeCount, expStrobes);

    // 0x3C with stop bit 0, then break for 3 frame times
    expectFrame(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'h3C, 8, 0, 1'b0, 1'b0, 0, 1'b0);
    repeat (30) sendBit(1'b0);
    idleBits(2);
    checkOutput("break_one_strobe", strobeCount, expStrobes);
    expectFrame(8'h55, 1'b0, 1'b0);
    applyStimulus(8'h55, 8, 0, 1'b0, 1'b1, 0, 1'b1);
    idleBits(1);

    // Overrun on full FIFO, sticky until err_clr
    fifo_full = 1'b1;
    applyStimulus(8'h42, 8, 0, 1'b0, 1'b1, 0, 1'b1);
    idleBits(1);
    checkOutput("ovr_set", overrun_err, 1'b1);
    checkOutput("ovr_no_strobe", strobeCount, expStrobes);
    fifo_full = 1'b0;
    expectFrame(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h11, 8, 0, 1'b0, 1'b1, 0, 1'b1);
    idleBits(1);
    checkOutput("ovr_sticky", overrun_err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("ovr_cleared", overrun_err, 1'b0);

    // Even parity, 0x07 (three ones) with a wrong parity bit of 0
    parity_type = 2'b01;
`ifdef UART_RX_PARITY_EN
    expectFrame(8'h07, 1'b0, 1'b1);
`else
    expectFrame(8'h07, 1'b1, 1'b0);
`endif
    applyStimulus(8'h07, 8, 1, 1'b0, 1'b1, 0, 1'b1);
    idleBits(2);

    // Odd parity, 7 bits, 0x5A (four ones) so the correct parity bit is 1
    parity_type     = 2'b10;
    data_bits_count = 2'd2;
    expectFrame(8'h5A, 1'b0, 1'b0);
    applyStimulus(8'h5A, 7, 1, 1'b1, 1'b1, 0, 1'b1);
    idleBits(2);
    parity_type     = 2'b00;
    data_bits_count = 2'd3;

    // Two stop bits: clean, then second stop bit sampled 0
    double_stop_bits = 1'b1;
    expectFrame(8'hC3, 1'b0, 1'b0);
    applyStimulus(8'hC3, 8, 0, 1'b0, 1'b1, 1, 1'b1);
    idleBits(1);
    expectFrame(8'h81, 1'b1, 1'b0);
    applyStimulus(8'h81, 8, 0, 1'b0, 1'b1, 1, 1'b0);
    idleBits(2);
    double_stop_bits = 1'b0;

    // Reset mid-frame aborts without a push
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_dout", dout, 8'h00);
    checkOutput("rstmid_valid", dout_valid, 1'b0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    idleBits(3);
    checkOutput("rstmid_no_strobe", strobeCount, expStrobes);

    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART peripheral. Deserialises asynchronous frames from the `rxd` line using a 16x oversampling enable from the UART clock divider chain. Validates start, parity and stop bits, and pushes each completed character into the RX FIFO write port with per-character error flags. Frame format comes from config register B fields and is latched per frame.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `sample_tick` pulses per bit period. Power of two, ≥ 8.
- `SYNC_STAGES`, 2: flip-flop stages in the `rxd` synchronizer.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `sample_tick`  input  1  one-`clk` enable at `OVERSAMPLE` x baud.
- `rxd`  input  1  serial line, idle high, asynchronous.
- `data_bits_count`  input  2  0..3 selects 5..8 data bits.
- `parity_type`  input  2  00 none, 01 even, 10 odd, 11 none.
- `double_stop_bits`  input  1  1 selects two stop bits.
- `fifo_full`  input  1  RX FIFO full.
- `err_clr`  input  1  clears `overrun_err`.
- `dout`  output  8  received character, right-aligned, unused upper bits 0.
- `dout_valid`  output  1  one-cycle push strobe to the RX FIFO `we`.
- `frame_err`  output  1  qualifies `dout_valid`: a stop bit was sampled 0.
- `parity_err`  output  1  qualifies `dout_valid`: parity mismatch.
- `overrun_err`  output  1  sticky: a character was dropped because the FIFO was full.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rxd` passes through `SYNC_STAGES` flip-flops, each reset to 1. All logic uses the synchronized value `rxs`.
- `last_s` holds `rxs` as seen at the previous `sample_tick`. It resets to 1.
- Sample counter: `$clog2(OVERSAMPLE)` bits. It advances only on `sample_tick` and is cleared on every state entry.
- **IDLE**: on a `sample_tick` where `rxs`=0 and `last_s`=1, latch the frame config and go to START.
  - Start detection is edge-based, so a held-low line (break) yields at most one frame.
- **START**: on the (`OVERSAMPLE`/2)th tick after detection, sample `rxs`.
  - If 1: false start, return to IDLE. No strobe, no flag.
  - If 0: go to DATA with bit index 0.
- **DATA**: sample every `OVERSAMPLE` ticks, at mid-bit. Bits arrive LSB first; sample i is written to `shift[i]`.
  - After N = `data_bits_count`+5 samples, go to PARITY if parity is enabled, otherwise STOP1.
- **PARITY**: one mid-bit sample.
  - Even: XOR of data bits and parity bit must be 0.
  - Odd: that XOR must be 1.
  - A mismatch records a pending parity error. Then go to STOP1.
- **STOP1**: one mid-bit sample; a 0 records a pending frame error.
  - If `double_stop_bits` is latched 1, go to STOP2; otherwise complete the frame.
- **STOP2**: same sampling and error rule as STOP1, then complete the frame.
- **Frame complete**:
  - If `fifo_full`=0: pulse `dout_valid`, present `dout`, `frame_err` and `parity_err`.
  - If `fifo_full`=1: no strobe; set `overrun_err`.
  - In either case return to IDLE.
- A frame with a frame error is still pushed, with `frame_err`=1.
- Config inputs changing mid-frame have no effect until the next start detection.
- `overrun_err` clears on `err_clr`. If `err_clr` and a new overrun occur in the same cycle, the set wins.

## Timing
- Reset values:
  - `dout`=0, `dout_valid`=0, `frame_err`=0, `parity_err`=0, `overrun_err`=0, `busy`=0.
  - State IDLE; synchronizer and `last_s` all 1.
- Asserting `reset` mid-frame aborts the frame immediately and pushes nothing.
- Sampling: START is sampled 8 ticks after the detecting tick (for `OVERSAMPLE`=16). Every later sample follows the previous one by exactly 16 ticks.
- `dout_valid` rises on the `clk` edge after the `sample_tick` carrying the last stop sample. It lasts exactly one `clk`.
- `dout` and the error flags are valid with `dout_valid` and hold their values until the next completed frame.
- Input-to-decision latency is `SYNC_STAGES` `clk` cycles plus the sampling instant.
- For single-stop frames, the FSM is back in IDLE from mid-stop-bit onward, so back-to-back frames are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state and `parity_type` decoding are compiled in.
- `UART_RX_PARITY_EN` undefined:
  - `parity_type` is ignored and the frame goes DATA→STOP1.
  - `parity_err` is tied to 0.

## Test plan
- 8N1, byte 0xA5, `OVERSAMPLE`=16 → one `dout_valid`, `dout`=0xA5, all errors 0, `busy` back to 0.
- `data_bits_count`=0 (5 bits), send 0x15 → `dout`=0x15, bits [7:5]=0.
- Low glitch on `rxd` lasting 4 ticks → START rejects it; no `dout_valid`; `busy` high for 8 ticks only.
- 0x3C with stop bit 0, then line held low for 3 frame times → exactly one `dout_valid` with `frame_err`=1. The next frame after the line returns high is received cleanly.
- `fifo_full`=1 at completion of 0x42 → no `dout_valid`, `overrun_err`=1. It stays 1 through the next frame and clears on `err_clr`.
- With `UART_RX_PARITY_EN` and even parity, send 0x07 with parity bit 0 → `dout`=0x07, `parity_err`=1. With the macro undefined, the same frame gives `frame_err`=1, because the parity bit is taken as the stop bit.
